// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential signed multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;

  // The iteration counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/twos_neg.sv
// Combinational conditional two's-complement negate: dout = neg ? -din : din.
module twos_neg #(
  parameter int W = 3
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mul_seq.sv
// Signed shift-add multiplier, one multiplier bit per clock; done rises WIDTH+1 edges after start.
// start is only sampled while idle and is dropped (not queued) while busy.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ZF,
  output logic                 SF,
  output logic                 OVF
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t               state;
  state_t               state_nxt;
  logic                 load;
  logic                 fin;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     mag_a;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   res;
  logic [WIDTH:0]       res_hi;

  // |-2^(WIDTH-1)| keeps the same bit pattern, which reads correctly as unsigned.
  twos_neg #(.W(WIDTH)) u_abs_a (
    .din  (A),
    .neg  (A[WIDTH-1]),
    .dout (abs_a)
  );

  twos_neg #(.W(WIDTH)) u_abs_b (
    .din  (B),
    .neg  (B[WIDTH-1]),
    .dout (abs_b)
  );

  twos_neg #(.W(2*WIDTH)) u_fix (
    .din  (acc),
    .neg  (neg),
    .dout (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Upper half plus carry; the low half of acc doubles as the shifting multiplier.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      mag_a <= abs_a;
      acc   <= {{WIDTH{1'b0}}, abs_b};
      neg   <= A[WIDTH-1] ^ B[WIDTH-1];
      cnt   <= CNT_W'(WIDTH);
    end else if (state == CALC) begin
      acc   <= {sum, acc[WIDTH-1:1]};
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // The product fits WIDTH signed bits only when its top WIDTH+1 bits agree.
  assign res_hi = res[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      P    <= '0;
      ZF   <= 1'b0;
      SF   <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        P   <= res;
        ZF  <= (res == '0);
        SF  <= res[2*WIDTH-1];
        OVF <= !((&res_hi) || (~|res_hi));
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq at WIDTH=3: expected results queued at start, checked at done.
module tb_mul_seq;

  localparam int W = 3;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic           zf;
    logic           sf;
    logic           ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  logic           zf;
  logic           sf;
  logic           ovf;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .P     (p),
    .ZF    (zf),
    .SF    (sf),
    .OVF   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    int sa, sbv, pr;
    sa  = int'($signed(ia));
    sbv = int'($signed(ib));
    pr  = sa * sbv;
    e.p   = pr[2*W-1:0];
    e.zf  = (pr == 0);
    e.sf  = (pr < 0);
    e.ovf = (pr < -(1 << (W-1))) || (pr > (1 << (W-1)) - 1);
    return e;
  endfunction

  function automatic exp_t mk(input logic [2*W-1:0] ep, input logic ez, input logic es, input logic eo);
    exp_t e;
    e.p = ep; e.zf = ez; e.sf = es; e.ovf = eo;
    return e;
  endfunction

  // Drive one start pulse and queue its expected result; returns 1ns after the start edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input exp_t e);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Edges counted from the call until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1; a = 3'b011; b = 3'b011;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, p, zf, sf, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b P=%b ZF=%b SF=%b OVF=%b, want all 0",
               busy, done, p, zf, sf, ovf);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    exp_t         te [4];
    exp_t         e;
    int           lat;
    ta[0] = 3'b011; tb[0] = 3'b011; te[0] = mk(6'b001001, 1'b0, 1'b0, 1'b1);
    ta[1] = 3'b100; tb[1] = 3'b100; te[1] = mk(6'b010000, 1'b0, 1'b0, 1'b1);
    ta[2] = 3'b111; tb[2] = 3'b011; te[2] = mk(6'b111101, 1'b0, 1'b1, 1'b0);
    ta[3] = 3'b000; tb[3] = 3'b101; te[3] = mk(6'b000000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], te[i]);
      vectors++;
      if (!busy) begin
        miscompares++;
        $display("FAIL basic_busy[%0d]: got busy=%b, want 1", i, busy);
      end
      wait_done(lat);
      e = sb.pop_front();
      vectors++;
      if (lat != 4) begin
        miscompares++;
        $display("FAIL basic_latency[%0d]: got %0d edges, want 4", i, lat);
      end
      vectors++;
      if ({p, zf, sf, ovf} !== e) begin
        miscompares++;
        $display("FAIL basic_result[%0d]: got P=%b ZF=%b SF=%b OVF=%b, want P=%b ZF=%b SF=%b OVF=%b",
                 i, p, zf, sf, ovf, e.p, e.zf, e.sf, e.ovf);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || {p, zf, sf, ovf} !== e) begin
        miscompares++;
        $display("FAIL basic_hold[%0d]: got done=%b busy=%b P=%b, want done=0 busy=0 P=%b",
                 i, done, busy, p, e.p);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    exp_t prev;
    int   lat;
    int   extra;
    prev = mk(p, zf, sf, ovf);
    issue(3'b010, 3'b010, mk(6'b000100, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || {p, zf, sf, ovf} !== prev) begin
      miscompares++;
      $display("FAIL busy_hold: got busy=%b P=%b, want busy=1 P=%b", busy, p, prev.p);
    end
    a = 3'b011; b = 3'b011; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    e = sb.pop_front();
    vectors++;
    if (lat < 0 || {p, zf, sf, ovf} !== e) begin
      miscompares++;
      $display("FAIL busy_result: got lat=%0d P=%b OVF=%b, want P=%b OVF=%b", lat, p, ovf, e.p, e.ovf);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    vectors++;
    if (extra != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_no_requeue: got %0d extra done pulses busy=%b, want 0 and busy=0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    issue(3'b010, 3'b110, model(3'b010, 3'b110));
    wait_done(lat);
    e = sb.pop_front();
    vectors++;
    if (lat != 4 || {p, zf, sf, ovf} !== e) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d P=%b, want lat=4 P=%b", lat, p, e.p);
    end
    issue(3'b011, 3'b011, mk(6'b001001, 1'b0, 1'b0, 1'b1));
    wait_done(lat);
    e = sb.pop_front();
    vectors++;
    if (lat != 4 || {p, zf, sf, ovf} !== e) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d P=%b OVF=%b, want lat=4 P=%b OVF=%b", lat, p, ovf, e.p, e.ovf);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   lat;
    int   seen;
    @(negedge clk);
    a = 3'b011; b = 3'b011; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, p, zf, sf, ovf} !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got busy=%b done=%b P=%b ZF=%b SF=%b OVF=%b, want all 0",
               busy, done, p, zf, sf, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midreset_abandon: got %0d cycles with done/busy, want 0", seen);
    end
    issue(3'b111, 3'b011, mk(6'b111101, 1'b0, 1'b1, 1'b0));
    wait_done(lat);
    e = sb.pop_front();
    vectors++;
    if (lat != 4 || {p, zf, sf, ovf} !== e) begin
      miscompares++;
      $display("FAIL midreset_recover: got lat=%0d P=%b SF=%b, want lat=4 P=%b SF=%b", lat, p, sf, e.p, e.sf);
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    int   lat;
    logic [W-1:0] va, vb;
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        va = W'(i);
        vb = W'(j);
        issue(va, vb, model(va, vb));
        wait_done(lat);
        e = sb.pop_front();
        vectors++;
        if (lat != 4 || {p, zf, sf, ovf} !== e) begin
          miscompares++;
          $display("FAIL sweep[%b*%b]: got lat=%0d P=%b ZF=%b SF=%b OVF=%b, want lat=4 P=%b ZF=%b SF=%b OVF=%b",
                   va, vb, lat, p, zf, sf, ovf, e.p, e.zf, e.sf, e.ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential signed shift-add multiplier for the ALU datapath.
- It is the inverse of the remainder/division path: it rebuilds products where the remainder unit reduces operands.
- Accepts two signed WIDTH-bit operands on a start pulse and iterates one multiplier bit per clock.
- Returns a signed 2*WIDTH-bit product with ZF, SF and OVF flags in the same flag style as the rest of the ALU.

Parameters:
- WIDTH, 3, operand width in bits (two's complement); legal values are 2 to 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while the block is idle
- A  input  WIDTH  signed multiplicand; captured on the accepted start
- B  input  WIDTH  signed multiplier; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; P and the flags are valid from this cycle
- P  output  2*WIDTH  signed product; held until the next done
- ZF  output  1  P == 0
- SF  output  1  P[2*WIDTH-1]
- OVF  output  1  product not representable as a WIDTH-bit signed value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, P=0, ZF=0, SF=0, OVF=0.
  - All internal registers cleared.
  - A reset mid-operation abandons the computation; no done pulse is produced.
- States:
  - IDLE: busy=0. If start=1, capture |A| and |B| as unsigned WIDTH-bit magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned). Capture neg = A[msb]^B[msb]. Clear the accumulator, set cnt=WIDTH, go to CALC.
  - CALC: busy=1. Each cycle: if mag_b[0]=1, add mag_a to the upper accumulator half; then shift {acc,mag_b} right one place, keeping the carry. Decrement cnt. When cnt reaches 1, go to FIN on the next edge.
  - FIN: busy=1 for this cycle. Register P = neg ? -acc : acc. Register ZF, SF and OVF from that value. Pulse done for exactly one cycle. Return to IDLE.
- Latency:
  - start is sampled at edge k.
  - CALC occupies edges k+1 through k+WIDTH.
  - FIN ends at edge k+WIDTH+1, where done rises for one cycle; P and flags are valid from that cycle.
  - A new start may be accepted in the cycle done is high (state is already IDLE).
- Handshake:
  - start is ignored while busy=1; it is not queued.
  - A and B may change freely after capture.
- Zero operand: P=0 with ZF=1, SF=0, OVF=0, including (-x)*0; no negative zero.
- OVF=1 iff P < -2^(WIDTH-1) or P > 2^(WIDTH-1)-1.
- Flags and P change only on the done edge or on reset.

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE, CALC, FIN);
  - the default WIDTH constant;
  - a width-derived counter-size constant ($clog2(WIDTH+1)).
- One natural sub-module: twos_neg, a combinational conditional negate. It is reused for operand absolute value and for product sign fix-up.

Test Plan:
- 011 * 011 (3*3) -> done exactly 4 clocks after the start edge; P=001001, ZF=0, SF=0, OVF=1.
- 100 * 100 (-4*-4) -> P=010000, SF=0, ZF=0, OVF=1 (magnitude edge case).
- 111 * 011 (-1*3) -> P=111101, SF=1, ZF=0, OVF=0.
- 000 * 101 (0*-3) -> P=000000, ZF=1, SF=0, OVF=0.
- Start 010*010, then pulse start with 011*011 while busy -> only one done; P=000100, OVF=1. Back-to-back start in the done cycle is accepted.
- Start 011*011, deassert rst_n two cycles in -> all outputs 0 immediately, no done. A new start afterwards completes normally.
- Exhaustive sweep of all 64 operand pairs -> each P equals the signed reference product and the flags match.
